// File: rtl/sram_pkg.sv
// Shared SRAM constants and read-FSM state type, also used by the write driver.
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_PRE,
    RD_DEV,
    RD_SENSE,
    RD_DONE
  } rd_state_t;

endpackage

// File: rtl/sram_read_sense_if.sv
// Read-port bundle between requester, bit-line array and sram_read_sense.
interface sram_read_sense_if #(
  parameter int COLS = 8,
  parameter int ROWS = 16
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic             rd_req;
  logic [ROW_W-1:0] rd_row;
  real              bl_rd    [0:COLS-1];
  real              blb_rd   [0:COLS-1];
  logic             pre_en;
  logic [ROWS-1:0]  wl_en;
  logic             busy;
  real              data_out [0:COLS-1];
  logic             rd_valid;
  logic [COLS-1:0]  rd_err;

  modport master (
    output rd_req, rd_row, bl_rd, blb_rd,
    input  pre_en, wl_en, busy, data_out, rd_valid, rd_err
  );

  modport slave (
    input  rd_req, rd_row, bl_rd, blb_rd,
    output pre_en, wl_en, busy, data_out, rd_valid, rd_err
  );
endinterface

// File: rtl/sram_read_sense_amp.sv
// Per-column sense amplifier: resolves one real bl/blb pair into a bit.
// The marginal-difference flag is only built when SRAM_RD_MARGIN_CHK_EN is defined.
module sense_amp #(
  parameter real SENSE_MARGIN = 0.2
) (
  input  real  bl,
  input  real  blb,
  output logic bit_o,
  output logic err_o
);

  real diff;

  always_comb begin
    diff = bl - blb;
`ifdef SRAM_RD_MARGIN_CHK_EN
    if (diff >= SENSE_MARGIN) begin
      bit_o = 1'b1;
      err_o = 1'b0;
    end else if (diff <= -SENSE_MARGIN) begin
      bit_o = 1'b0;
      err_o = 1'b0;
    end else begin
      bit_o = (diff > 0.0);
      err_o = 1'b1;
    end
`else
    bit_o = (diff > 0.0);
    err_o = 1'b0;
`endif
  end

endmodule

// File: rtl/sram_read_sense.sv
// SRAM read sequencer: precharge, word-line development, sense, latch.
// Optional macro SRAM_RD_MARGIN_CHK_EN enables per-column rd_err margin flags.
module sram_read_sense
  import sram_pkg::*;
#(
  parameter int  COLS         = 8,
  parameter int  ROWS         = 16,
  parameter int  PRE_CYCLES   = 2,
  parameter int  DEV_CYCLES   = 3,
  parameter real SENSE_MARGIN = 0.2
) (
  input logic               clk,
  input logic               rst_n,
  sram_read_sense_if.slave  bus
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_MAX = (PRE_CYCLES > DEV_CYCLES) ? PRE_CYCLES : DEV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  rd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             pre_en_q, pre_en_d;
  logic [ROWS-1:0]  wl_en_q, wl_en_d;
  logic             rd_valid_q, rd_valid_d;
  logic [COLS-1:0]  data_bits_q, data_bits_d;
  logic [COLS-1:0]  rd_err_q, rd_err_d;
  logic [COLS-1:0]  sense_bit;
  logic [COLS-1:0]  sense_err;

  for (genvar i = 0; i < COLS; i++) begin : g_col
    sense_amp #(.SENSE_MARGIN(SENSE_MARGIN)) u_sa (
      .bl    (bus.bl_rd[i]),
      .blb   (bus.blb_rd[i]),
      .bit_o (sense_bit[i]),
      .err_o (sense_err[i])
    );
    assign bus.data_out[i] = data_bits_q[i] ? VDD : VSS;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    data_bits_d = data_bits_q;
    rd_err_d    = rd_err_q;
    case (state_q)
      RD_IDLE: begin
        if (bus.rd_req) begin
          state_d = RD_PRE;
          cnt_d   = CNT_W'(PRE_CYCLES - 1);
          row_d   = bus.rd_row;
        end
      end
      RD_PRE: begin
        if (cnt_q == '0) begin
          state_d = RD_DEV;
          cnt_d   = CNT_W'(DEV_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_DEV: begin
        if (cnt_q == '0) state_d = RD_SENSE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RD_SENSE: begin
        state_d     = RD_DONE;
        data_bits_d = sense_bit;
        rd_err_d    = sense_err;
      end
      RD_DONE:  state_d = RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase

    pre_en_d   = (state_d == RD_PRE);
    rd_valid_d = (state_d == RD_DONE);
    // An out-of-range row shifts the one past the top bit, leaving every word line low.
    wl_en_d    = ((state_d == RD_DEV) || (state_d == RD_SENSE)) ? (ROWS'(1) << row_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RD_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      pre_en_q    <= 1'b0;
      wl_en_q     <= '0;
      rd_valid_q  <= 1'b0;
      data_bits_q <= '0;
      rd_err_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      pre_en_q    <= pre_en_d;
      wl_en_q     <= wl_en_d;
      rd_valid_q  <= rd_valid_d;
      data_bits_q <= data_bits_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign bus.pre_en   = pre_en_q;
  assign bus.wl_en    = wl_en_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.busy     = (state_q != RD_IDLE);

endmodule

// File: tb/tb_sram_read_sense.sv
// Scoreboarded bench for sram_read_sense: a timing/decision model predicts every pin,
// a monitor pops expected read data whenever rd_valid is seen.
module tb_sram_read_sense;
  import sram_pkg::*;

  localparam int  COLS   = 8;
  localparam int  ROWS   = 16;
  localparam int  PRE    = 2;
  localparam int  DEV    = 3;
  localparam int  ROW_W  = 4;
  localparam real MARGIN = 0.2;
  localparam int  RD_LEN = PRE + DEV + 1;

  typedef struct packed {
    logic [COLS-1:0] bits;
    logic [COLS-1:0] err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int check_cnt = 0;
  int pass_cnt  = 0;

  exp_t             exp_q[$];
  int               edge_cnt  = 0;
  int               acc_edge  = -1;
  logic [ROW_W-1:0] acc_row   = '0;
  logic [COLS-1:0]  held_bits = '0;
  logic [COLS-1:0]  held_err  = '0;
  real              levels [6] = '{0.0, 0.2, 0.75, 0.8, 1.0, 1.5};

  sram_read_sense_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  sram_read_sense #(
    .COLS(COLS), .ROWS(ROWS), .PRE_CYCLES(PRE), .DEV_CYCLES(DEV), .SENSE_MARGIN(MARGIN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference decision: bit is the sign of the difference, weak pairs are flagged.
  function automatic exp_t sense_ref();
    exp_t e;
    real  d;
    e = '0;
    for (int i = 0; i < COLS; i++) begin
      d = bus.bl_rd[i] - bus.blb_rd[i];
      e.bits[i] = (d > 0.0);
`ifdef SRAM_RD_MARGIN_CHK_EN
      e.err[i] = (((d < 0.0) ? -d : d) < MARGIN);
`else
      e.err[i] = 1'b0;
`endif
    end
    return e;
  endfunction

  function automatic logic [2*COLS-1:0] data_code();
    logic [2*COLS-1:0] c;
    for (int i = 0; i < COLS; i++) begin
      if (bus.data_out[i] == VSS)      c[2*i +: 2] = 2'b00;
      else if (bus.data_out[i] == VDD) c[2*i +: 2] = 2'b01;
      else                             c[2*i +: 2] = 2'b11;
    end
    return c;
  endfunction

  // Model: tracks the edge of the accepted request; everything else follows from the offset.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      acc_edge  = -1;
      edge_cnt  = 0;
      held_bits = '0;
      held_err  = '0;
      exp_q.delete();
    end else begin
      edge_cnt++;
      if (acc_edge >= 0 && edge_cnt - acc_edge == RD_LEN) exp_q.push_back(sense_ref());
      if (acc_edge >= 0 && edge_cnt - acc_edge >= RD_LEN + 2) acc_edge = -1;
      if (acc_edge < 0 && bus.rd_req === 1'b1) begin
        acc_edge = edge_cnt;
        acc_row  = bus.rd_row;
      end
    end
  end

  // Pin-timing checker
  initial forever begin
    int              k;
    logic            active;
    logic [ROWS-1:0] exp_wl;
    @(posedge clk);
    #2;
    k      = edge_cnt - acc_edge;
    active = (acc_edge >= 0);
    exp_wl = '0;
    if (active && k >= PRE && k <= PRE + DEV) exp_wl[acc_row] = 1'b1;
    checkOutput("pre_en",   64'(bus.pre_en),   64'(active && k < PRE));
    checkOutput("wl_en",    64'(bus.wl_en),    64'(exp_wl));
    checkOutput("busy",     64'(bus.busy),     64'(active && k <= RD_LEN));
    checkOutput("rd_valid", 64'(bus.rd_valid), 64'(active && k == RD_LEN));
  end

  // Scoreboard monitor
  initial forever begin
    exp_t              e;
    logic [2*COLS-1:0] exp_code;
    @(posedge clk);
    #2;
    if (bus.rd_valid === 1'b1) begin
      checkOutput("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e         = exp_q.pop_front();
        held_bits = e.bits;
        held_err  = e.err;
      end
    end
    for (int i = 0; i < COLS; i++) exp_code[2*i +: 2] = {1'b0, held_bits[i]};
    checkOutput("data_out", 64'(data_code()), 64'(exp_code));
    checkOutput("rd_err",   64'(bus.rd_err),  64'(held_err));
  end

  task automatic random_lines();
    for (int i = 0; i < COLS; i++) begin
      bus.bl_rd[i]  = levels[$urandom_range(0, 5)];
      bus.blb_rd[i] = levels[$urandom_range(0, 5)];
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", 64'(bus.busy), 64'(0));
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [ROW_W-1:0] row);
    bus.rd_row = row;
    bus.rd_req = 1'b1;
    @(negedge clk);
    bus.rd_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    bus.rd_req = 1'b0;
    bus.rd_row = '0;
    for (int i = 0; i < COLS; i++) begin
      bus.bl_rd[i]  = VSS;
      bus.blb_rd[i] = VSS;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < COLS; i++) begin
      bus.bl_rd[i]  = VDD;
      bus.blb_rd[i] = VSS;
    end
    applyStimulus(4'd5);

    // Abort a read in the development phase
    for (int i = 0; i < COLS; i++) begin
      bus.bl_rd[i]  = VSS;
      bus.blb_rd[i] = VDD;
    end
    bus.rd_row = 4'd9;
    bus.rd_req = 1'b1;
    @(negedge clk);
    bus.rd_req = 1'b0;
    n = 0;
    while (bus.wl_en == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wl_rise", 64'(bus.wl_en), 64'(16'h0200));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wl_en",    64'(bus.wl_en),    64'(0));
    checkOutput("rst_pre_en",   64'(bus.pre_en),   64'(0));
    checkOutput("rst_busy",     64'(bus.busy),     64'(0));
    checkOutput("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    checkOutput("rst_data_out", 64'(data_code()),  64'(0));
    checkOutput("rst_rd_err",   64'(bus.rd_err),   64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < COLS; i++) begin
      bus.bl_rd[i]  = (i % 2 == 0) ? VSS : VDD;
      bus.blb_rd[i] = (i % 2 == 0) ? VDD : VSS;
    end
    applyStimulus(4'd2);

    for (int i = 0; i < COLS; i++) begin
      bus.bl_rd[i]  = VSS;
      bus.blb_rd[i] = VDD;
    end
    bus.bl_rd[3]  = 0.80;
    bus.blb_rd[3] = 0.75;
    applyStimulus(4'd12);

    // Request held high: only one acceptance per full read sequence
    bus.rd_req = 1'b1;
    repeat (40) begin
      bus.rd_row = 4'($urandom);
      random_lines();
      @(negedge clk);
    end
    bus.rd_req = 1'b0;
    wait_idle();

    repeat (300) begin
      bus.rd_req = ($urandom_range(0, 2) == 0);
      bus.rd_row = 4'($urandom);
      random_lines();
      @(negedge clk);
    end
    bus.rd_req = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    checkOutput("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
